// File: rtl/jag_dram_pager.sv
// jag_dram_pager: front-end sequencer for SDRAM controller channel 1.
// Converts Jaguar-side 32-bit read/write requests into single-cycle
// controller primitives (act/pch/reqr/reqw/ref). It keeps one row open
// (page mode) and owns the periodic refresh for the channel.
//
// Ports:
//   clk, init        clock and synchronous active-high reset
//   cpu_req/rnw      request valid (level, held until ack) and direction
//   cpu_addr         address bits [23:3]: row = [23:11], column = [10:3]
//   cpu_din/cpu_be   write data and byte enables
//   cpu_dout         read data, valid with cpu_ack
//   cpu_ack          one-cycle completion pulse
//   cpu_busy         request or refresh in progress
//   sd_addr/caddr    column (reads) / row on act, {5'b0,column} on write
//   sd_din/be/rnw    write data, byte enables and direction to the controller
//   sd_reqr/reqw     read / write command pulses
//   sd_act/pch/ref   activate / precharge / refresh command pulses
//   sd_dout          read data from the controller
module jag_dram_pager #(
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned ACT_WAIT     = 3,
  parameter int unsigned PCH_WAIT     = 3,
  parameter int unsigned REF_WAIT     = 9,
  parameter int unsigned RD_WAIT      = 8,
  parameter int unsigned WR_WAIT      = 4
) (
  input  logic        clk,
  input  logic        init,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [20:0] cpu_addr,
  input  logic [31:0] cpu_din,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_busy,
  output logic [7:0]  sd_addr,
  output logic [12:0] sd_caddr,
  output logic [31:0] sd_din,
  output logic [3:0]  sd_be,
  output logic        sd_rnw,
  output logic        sd_reqr,
  output logic        sd_reqw,
  output logic        sd_act,
  output logic        sd_pch,
  output logic        sd_ref,
  input  logic [31:0] sd_dout
);

  localparam int unsigned RC_W = $clog2(REF_INTERVAL);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REF_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PCH, S_ACT, S_RD, S_WR, S_REF
  } state_t;

  state_t          state, state_nx;
  logic            tgt_ref, tgt_ref_nx;   // precharge is ahead of a refresh, not an access
  logic [RC_W-1:0] ref_cnt;
  logic            ref_pend;
  logic [7:0]      wait_cnt;
  logic            row_open;
  logic [12:0]     open_row;

  logic [20:0]     lat_addr;
  logic [31:0]     lat_din;
  logic [3:0]      lat_be;
  logic            lat_rnw;

  // A request still high during its own ack cycle is not a new request.
  logic            accept;
  logic            accept_go;
  logic [20:0]     cur_addr;
  logic [31:0]     cur_din;
  logic [3:0]      cur_be;
  logic [12:0]     cur_row;
  logic [7:0]      cur_col;
  logic            wait_done;
  logic            ref_expire;

  logic            issue, p_act, p_pch, p_rd, p_wr, p_ref, ack_nx, rd_done;
  logic [7:0]      wait_ld;

  assign accept     = cpu_req && !cpu_ack;
  assign accept_go  = (state == S_IDLE) && !ref_pend && accept;
  // Commands pulsed straight out of IDLE use the live inputs; later ones use the latch.
  assign cur_addr   = (state == S_IDLE) ? cpu_addr : lat_addr;
  assign cur_din    = (state == S_IDLE) ? cpu_din  : lat_din;
  assign cur_be     = (state == S_IDLE) ? cpu_be   : lat_be;
  assign cur_row    = cur_addr[20:8];
  assign cur_col    = cur_addr[7:0];
  assign wait_done  = (wait_cnt == '0);
  assign ref_expire = (ref_cnt == RC_LAST);
  assign cpu_busy   = (state != S_IDLE) || ref_pend || accept;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (init) begin
      state    <= S_IDLE;
      tgt_ref  <= 1'b0;
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
      wait_cnt <= '0;
      row_open <= 1'b0;
      open_row <= '0;
      lat_addr <= '0;
      lat_din  <= '0;
      lat_be   <= '0;
      lat_rnw  <= 1'b0;
      cpu_dout <= '0;
      cpu_ack  <= 1'b0;
      sd_addr  <= '0;
      sd_caddr <= '0;
      sd_din   <= '0;
      sd_be    <= '0;
      sd_rnw   <= 1'b0;
      sd_reqr  <= 1'b0;
      sd_reqw  <= 1'b0;
      sd_act   <= 1'b0;
      sd_pch   <= 1'b0;
      sd_ref   <= 1'b0;
    end else begin
      state   <= state_nx;
      tgt_ref <= tgt_ref_nx;

      ref_cnt <= ref_expire ? '0 : ref_cnt + 1'b1;
      if (ref_expire)
        ref_pend <= 1'b1;
      else if (p_ref)
        ref_pend <= 1'b0;

      if (issue)
        wait_cnt <= wait_ld;
      else if (!wait_done)
        wait_cnt <= wait_cnt - 1'b1;

      if (accept_go) begin
        lat_addr <= cpu_addr;
        lat_din  <= cpu_din;
        lat_be   <= cpu_be;
        lat_rnw  <= cpu_rnw;
      end

      if (p_pch || p_ref)
        row_open <= 1'b0;
      else if (p_act) begin
        row_open <= 1'b1;
        open_row <= cur_row;
      end

      sd_act  <= p_act;
      sd_pch  <= p_pch;
      sd_reqr <= p_rd;
      sd_reqw <= p_wr;
      sd_ref  <= p_ref;
      cpu_ack <= ack_nx;

      if (rd_done)
        cpu_dout <= sd_dout;
      if (p_act)
        sd_caddr <= cur_row;
      if (p_rd) begin
        sd_addr <= cur_col;
        sd_rnw  <= 1'b1;
      end
      if (p_wr) begin
        sd_caddr <= {5'b0, cur_col};
        sd_din   <= cur_din;
        sd_be    <= cur_be;
        sd_rnw   <= 1'b0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx   = state;
    tgt_ref_nx = tgt_ref;
    case (state)
      S_IDLE: begin
        if (ref_pend) begin
          tgt_ref_nx = 1'b1;
          state_nx   = row_open ? S_PCH : S_REF;
        end else if (accept) begin
          tgt_ref_nx = 1'b0;
          if (row_open && (cur_row == open_row))
            state_nx = cpu_rnw ? S_RD : S_WR;
          else if (row_open)
            state_nx = S_PCH;
          else
            state_nx = S_ACT;
        end
      end
      S_PCH:   if (wait_done) state_nx = tgt_ref ? S_REF : S_ACT;
      S_ACT:   if (wait_done) state_nx = lat_rnw ? S_RD : S_WR;
      S_RD,
      S_WR,
      S_REF:   if (wait_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode: a command is pulsed on every move into a command state.
  always_comb begin
    issue   = (state_nx != state) && (state_nx != S_IDLE);
    p_act   = issue && (state_nx == S_ACT);
    p_pch   = issue && (state_nx == S_PCH);
    p_rd    = issue && (state_nx == S_RD);
    p_wr    = issue && (state_nx == S_WR);
    p_ref   = issue && (state_nx == S_REF);
    rd_done = (state == S_RD) && (state_nx == S_IDLE);
    ack_nx  = ((state == S_RD) || (state == S_WR)) && (state_nx == S_IDLE);
    case (state_nx)
      S_PCH:   wait_ld = 8'(PCH_WAIT - 1);
      S_ACT:   wait_ld = 8'(ACT_WAIT - 1);
      S_RD:    wait_ld = 8'(RD_WAIT - 1);
      S_WR:    wait_ld = 8'(WR_WAIT - 1);
      S_REF:   wait_ld = 8'(REF_WAIT - 1);
      default: wait_ld = '0;
    endcase
  end

endmodule

// File: tb/tb_jag_dram_pager.sv
module tb_jag_dram_pager;

  logic        clk = 1'b0;
  logic        init;
  logic        cpu_req;
  logic        cpu_rnw;
  logic [20:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_dout;
  logic        cpu_ack;
  logic        cpu_busy;
  logic [7:0]  sd_addr;
  logic [12:0] sd_caddr;
  logic [31:0] sd_din;
  logic [3:0]  sd_be;
  logic        sd_rnw;
  logic        sd_reqr;
  logic        sd_reqw;
  logic        sd_act;
  logic        sd_pch;
  logic        sd_ref;
  logic [31:0] sd_dout;

  jag_dram_pager #(
    .REF_INTERVAL(780),
    .ACT_WAIT(3),
    .PCH_WAIT(3),
    .REF_WAIT(9),
    .RD_WAIT(8),
    .WR_WAIT(4)
  ) dut (
    .clk(clk), .init(init),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_be(cpu_be), .cpu_dout(cpu_dout),
    .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
    .sd_addr(sd_addr), .sd_caddr(sd_caddr), .sd_din(sd_din), .sd_be(sd_be),
    .sd_rnw(sd_rnw), .sd_reqr(sd_reqr), .sd_reqw(sd_reqw),
    .sd_act(sd_act), .sd_pch(sd_pch), .sd_ref(sd_ref), .sd_dout(sd_dout)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int ecount = 0;   // clock edges since init was released
  int n_act  = 0;
  int n_ack  = 0;
  int n_ref  = 0;
  logic [4:0] prev_p = '0;
  logic [4:0] cur_p;

  always @(posedge clk) ecount <= init ? 0 : ecount + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Pulses are one cycle wide and never coincide.
  always @(negedge clk) begin
    cur_p = {sd_act, sd_pch, sd_reqr, sd_reqw, sd_ref};
    if (!init)
      check("pulse_shape", 32'(($onehot0(cur_p) && ((cur_p & prev_p) == '0))), 32'd1);
    prev_p = cur_p;
    n_act += int'(sd_act);
    n_ack += int'(cpu_ack);
    n_ref += int'(sd_ref);
  end

  function automatic logic sig(input int s);
    case (s)
      0: return sd_act;
      1: return sd_pch;
      2: return sd_reqr;
      3: return sd_reqw;
      4: return sd_ref;
      default: return cpu_ack;
    endcase
  endfunction

  localparam int ACT = 0, PCH = 1, RDP = 2, WRP = 3, REF = 4, ACK = 5;

  task automatic wait_sig(input string tag, input int s, input int bound, output int at);
    at = -1;
    for (int i = 0; i <= bound; i++) begin
      if (sig(s)) begin
        at = ecount;
        break;
      end
      @(negedge clk);
    end
    check(tag, 32'(at >= 0), 32'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t0, t_act, t_pch, t_rd, t_wr, t_ack, t_ref, t_ref2, acks0, acts0;

  initial begin
    init = 1'b1; cpu_req = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0;
    cpu_din = '0; cpu_be = '0; sd_dout = '0;
    step(3);
    check("reset_pulses", 32'({sd_act, sd_pch, sd_reqr, sd_reqw, sd_ref, cpu_ack}), 32'd0);
    check("reset_dout", cpu_dout, 32'd0);
    check("reset_busy", 32'(cpu_busy), 32'd0);
    init = 1'b0;

    // Read with the row closed: act, then reqr 3 later, ack 8 after that
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = {13'd5, 8'h12}; sd_dout = 32'hDEADBEEF;
    wait_sig("t1_act_seen", ACT, 4, t_act);
    check("t1_act_caddr", 32'(sd_caddr), 32'd5);
    check("t1_busy", 32'(cpu_busy), 32'd1);
    cpu_addr = {13'd7, 8'h55};   // must be ignored: request was already latched
    wait_sig("t1_rd_seen", RDP, 10, t_rd);
    check("t1_act_to_rd", 32'(t_rd - t_act), 32'd3);
    check("t1_rd_addr", 32'(sd_addr), 32'h12);
    check("t1_rd_rnw", 32'(sd_rnw), 32'd1);
    wait_sig("t1_ack_seen", ACK, 12, t_ack);
    check("t1_rd_to_ack", 32'(t_ack - t_rd), 32'd8);
    check("t1_dout", cpu_dout, 32'hDEADBEEF);
    cpu_req = 1'b0;
    step(1);
    check("t1_idle_busy", 32'(cpu_busy), 32'd0);

    // Page hit: no act, reqr the cycle after acceptance
    acts0 = n_act;
    cpu_req = 1'b1; cpu_addr = {13'd5, 8'h13}; sd_dout = 32'hCAFEF00D;
    t0 = ecount;
    wait_sig("t2_rd_seen", RDP, 10, t_rd);
    check("t2_accept_to_rd", 32'(t_rd - t0), 32'd1);
    check("t2_rd_addr", 32'(sd_addr), 32'h13);
    wait_sig("t2_ack_seen", ACK, 12, t_ack);
    check("t2_rd_to_ack", 32'(t_ack - t_rd), 32'd8);
    check("t2_dout", cpu_dout, 32'hCAFEF00D);
    check("t2_no_act", 32'(n_act - acts0), 32'd0);
    cpu_req = 1'b0;
    step(1);

    // Page miss: pch, act (row 9) 3 later, reqr 3 later
    cpu_req = 1'b1; cpu_addr = {13'd9, 8'h01}; sd_dout = 32'h01020304;
    t0 = ecount;
    wait_sig("t3_pch_seen", PCH, 4, t_pch);
    check("t3_accept_to_pch", 32'(t_pch - t0), 32'd1);
    wait_sig("t3_act_seen", ACT, 6, t_act);
    check("t3_pch_to_act", 32'(t_act - t_pch), 32'd3);
    check("t3_act_caddr", 32'(sd_caddr), 32'd9);
    wait_sig("t3_rd_seen", RDP, 6, t_rd);
    check("t3_act_to_rd", 32'(t_rd - t_act), 32'd3);
    wait_sig("t3_ack_seen", ACK, 12, t_ack);
    check("t3_dout", cpu_dout, 32'h01020304);
    cpu_req = 1'b0;
    step(1);

    // Write hitting row 9 (proves open_row is 9)
    acts0 = n_act;
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = {13'd9, 8'h40};
    cpu_din = 32'h11223344; cpu_be = 4'b0110;
    t0 = ecount;
    wait_sig("t4_wr_seen", WRP, 6, t_wr);
    check("t4_accept_to_wr", 32'(t_wr - t0), 32'd1);
    check("t4_wr_caddr", 32'(sd_caddr), 32'h040);
    check("t4_wr_din", sd_din, 32'h11223344);
    check("t4_wr_be", 32'(sd_be), 32'b0110);
    check("t4_wr_rnw", 32'(sd_rnw), 32'd0);
    wait_sig("t4_ack_seen", ACK, 8, t_ack);
    check("t4_wr_to_ack", 32'(t_ack - t_wr), 32'd4);
    check("t4_no_act", 32'(n_act - acts0), 32'd0);

    // Request held through ack becomes a new one; be=0 write still issued and acked
    cpu_addr = {13'd9, 8'h41}; cpu_be = 4'b0000; cpu_din = 32'hA5A5A5A5;
    wait_sig("t5_wr_seen", WRP, 6, t_wr);
    check("t5_ack_to_wr", 32'(t_wr - t_ack), 32'd2);
    cpu_req = 1'b0;
    check("t5_wr_be", 32'(sd_be), 32'd0);
    check("t5_wr_caddr", 32'(sd_caddr), 32'h041);
    wait_sig("t5_ack_seen", ACK, 8, t_ack);
    check("t5_wr_to_ack", 32'(t_ack - t_wr), 32'd4);

    // Refresh vs. request with row 9 open: pch, ref, act, access
    for (int i = 0; i < 1000 && ecount != 780; i++) step(1);
    check("t6_no_early_ref", 32'(n_ref), 32'd0);
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = {13'd9, 8'h20}; sd_dout = 32'h55AA55AA;
    wait_sig("t6_pch_seen", PCH, 4, t_pch);
    check("t6_pch_cycle", 32'(t_pch), 32'd781);
    wait_sig("t6_ref_seen", REF, 6, t_ref);
    check("t6_pch_to_ref", 32'(t_ref - t_pch), 32'd3);
    wait_sig("t6_act_seen", ACT, 14, t_act);
    check("t6_ref_to_act", 32'(t_act - t_ref), 32'd10);
    check("t6_act_caddr", 32'(sd_caddr), 32'd9);
    wait_sig("t6_rd_seen", RDP, 6, t_rd);
    check("t6_act_to_rd", 32'(t_rd - t_act), 32'd3);
    wait_sig("t6_ack_seen", ACK, 12, t_ack);
    check("t6_dout", cpu_dout, 32'h55AA55AA);
    cpu_req = 1'b0;
    step(1);
    wait_sig("t6_ref2_seen", REF, 800, t_ref2);
    check("t6_ref_period", 32'(t_ref2 - t_ref), 32'd780);
    step(12);

    // init 2 cycles into an ACT wait: abandoned, no ack, next read re-activates
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = {13'd3, 8'h05}; sd_dout = 32'h0BADF00D;
    wait_sig("t7_act_seen", ACT, 4, t_act);
    step(2);
    acks0 = n_ack;
    init = 1'b1;
    step(1);
    check("t7_reset_pulses", 32'({sd_act, sd_pch, sd_reqr, sd_reqw, sd_ref, cpu_ack}), 32'd0);
    check("t7_reset_dout", cpu_dout, 32'd0);
    check("t7_reset_caddr", 32'(sd_caddr), 32'd0);
    step(1);
    init = 1'b0;
    wait_sig("t7_act2_seen", ACT, 4, t_act);
    check("t7_act2_caddr", 32'(sd_caddr), 32'd3);
    check("t7_no_ack", 32'(n_ack - acks0), 32'd0);
    wait_sig("t7_ack_seen", ACK, 14, t_ack);
    check("t7_act_to_ack", 32'(t_ack - t_act), 32'd11);
    check("t7_dout", cpu_dout, 32'h0BADF00D);
    cpu_req = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/jag_dram_pager.md
Name: jag_dram_pager

Overview:
- Front-end sequencer for the SDRAM controller's DRAM channel (ch1).
- Turns simple Jaguar-side 32-bit read/write requests into the controller's primitive pulses: activate, precharge, read, write and refresh.
- Tracks one open row (page mode): page hits skip the activate; page misses are preceded by precharge and activate.
- Owns periodic refresh for ch1; the controller runs with self_refresh=0.

Parameters:
- REF_INTERVAL, 780: clk cycles between refresh requests.
- ACT_WAIT, 3: cycles from sd_act pulse until the next command may be pulsed.
- PCH_WAIT, 3: cycles from sd_pch pulse until the next command.
- REF_WAIT, 9: cycles from sd_ref pulse until the next command.
- RD_WAIT, 8: cycles from sd_reqr pulse until sd_dout is valid and is sampled.
- WR_WAIT, 4: cycles from sd_reqw pulse until the write is complete.

Ports:
- clk, in, 1: system clock, same as the SDRAM controller.
- init, in, 1: synchronous active-high reset.
- cpu_req, in, 1: request valid (level); held until cpu_ack.
- cpu_rnw, in, 1: 1 = read, 0 = write.
- cpu_addr, in, 21: address bits [23:3]. Row = [23:11], column = [10:3].
- cpu_din, in, 32: write data.
- cpu_be, in, 4: byte enables, active high.
- cpu_dout, out, 32: read data.
- cpu_ack, out, 1: one-cycle completion pulse.
- cpu_busy, out, 1: high while a request or refresh is in progress.
- sd_addr, out, 8: column, to ch1_addr[10:3].
- sd_caddr, out, 13: to ch1_caddr. Carries the row during act, {5'b0, column} during write.
- sd_din, out, 32: to ch1_din.
- sd_be, out, 4: to ch1_be.
- sd_rnw, out, 1: to ch1_rnw.
- sd_reqr, out, 1: read pulse, to ch1_reqr.
- sd_reqw, out, 1: write pulse, to ch1_reqw.
- sd_act, out, 1: activate pulse, to ch1_act.
- sd_pch, out, 1: precharge pulse, to ch1_pch.
- sd_ref, out, 1: refresh pulse, to ch1_ref.
- sd_dout, in, 32: from ch1_dout.

Behaviour:
- Reset (init=1 at a clk edge):
  - all outputs 0, state IDLE, row_open=0, open_row=0, ref_cnt=0, ref_pend=0, wait counter 0.
  - Applies mid-operation too: any in-flight sequence is abandoned with no ack. The controller is reset by the same init.
- Command pulses:
  - sd_act, sd_pch, sd_reqr, sd_reqw and sd_ref are each exactly one cycle wide.
  - At most one pulse per cycle.
  - sd_addr, sd_caddr, sd_din, sd_be and sd_rnw are set in the same cycle as their pulse and held until the next pulse.
- Wait counter: loaded with X_WAIT-1 on each pulse. The next pulse is allowed on the cycle after it reads 0.
- Refresh timer:
  - ref_cnt increments every cycle.
  - At ref_cnt == REF_INTERVAL-1: ref_cnt <= 0 and ref_pend <= 1.
  - ref_pend is sticky until sd_ref is issued; a second expiry while pending is not counted.
- States:
  - IDLE
    - If ref_pend: go to PCH (row_open=1) or REF (row_open=0), with target = refresh.
    - Else if cpu_req: compute row = cpu_addr[23:11], then:
      - hit (row_open && row == open_row): go to RD or WR;
      - miss (row_open, different row): go to PCH, target = access;
      - closed (row_open=0): go to ACT.
    - Refresh has priority when ref_pend and cpu_req are both set.
    - cpu_busy = 0 only in IDLE with no pending start.
  - PCH: pulse sd_pch; set row_open <= 0; after PCH_WAIT go to REF (target refresh) or ACT (target access).
  - ACT: pulse sd_act with sd_caddr = row; set open_row <= row and row_open <= 1; after ACT_WAIT go to RD or WR.
  - RD: pulse sd_reqr with sd_addr = column and sd_rnw = 1. After RD_WAIT, cpu_dout <= sd_dout, pulse cpu_ack, return to IDLE.
  - WR: pulse sd_reqw with sd_caddr = {5'b0, column}, sd_din = cpu_din, sd_be = cpu_be, sd_rnw = 0. After WR_WAIT, pulse cpu_ack, return to IDLE.
  - REF: pulse sd_ref; clear ref_pend; row_open <= 0 (the controller closes the row on refresh). After REF_WAIT return to IDLE.
- Request capture:
  - cpu_addr, cpu_din, cpu_be and cpu_rnw are latched when IDLE accepts the request.
  - Later changes on those inputs are ignored until ack.
- cpu_req still high on the cycle after ack is treated as a new request.
- A refresh never interrupts an access. ref_pend raised mid-access is served in the next IDLE.
- cpu_be = 0 on a write is still issued (no-op write) and acked.

Test Plan:
- Read, row closed: read at cpu_addr row 5, column 0x12, with sd_dout = 0xDEADBEEF at sample time.
  - sd_act with caddr = 5.
  - sd_reqr 3 cycles later with sd_addr = 0x12.
  - cpu_ack 8 cycles after that, cpu_dout = 0xDEADBEEF.
- Page hit: second read, row 5, column 0x13 → no sd_act; sd_reqr on the cycle after IDLE accepts; ack 8 cycles later.
- Page miss: read at row 9.
  - Order: sd_pch, then sd_act with caddr = 9 (3 cycles later), then sd_reqr (3 cycles later).
  - open_row becomes 9.
- Write at row 9, column 0x40, din 0x11223344, be 4'b0110 → sd_reqw with sd_caddr = 0x040, sd_din = 0x11223344, sd_be = 0110, sd_rnw = 0; ack 4 cycles later.
- Refresh vs. request, row open: ref_cnt expires with cpu_req high in the same cycle.
  - Order: sd_pch, sd_ref, then sd_act, then the access.
  - Refresh pulses recur every 780 cycles in idle.
- init asserted 2 cycles into an ACT wait → no ack, all pulses 0, row_open = 0; the next read starts with sd_act.
